// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: scanner FSM state encoding, default matrix size and timer sizing helper
package led_matrix_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_BLANK, ST_FETCH, ST_SHIFT_LO, ST_SHIFT_HI, ST_LATCH, ST_DISPLAY
  } state_t;
  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/led_matrix_scanner_phase_timer.sv
// phase_timer: loadable down-counter (clk, rst, load, val) with done high while the count is zero
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-multiplexed LED matrix driver (clk, rst, en, rd_row/rd_data frame-buffer read, ser/srclk/rclk shift chain, oe_n, row_sel, frame_done)
module led_matrix_scanner import led_matrix_pkg::*; #(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int DIV   = 4,
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [COLS-1:0]         rd_data,
  output logic                    ser,
  output logic                    srclk,
  output logic                    rclk,
  output logic                    oe_n,
  output logic [ROWS-1:0]         row_sel,
  output logic                    frame_done
);
  localparam int RW = $clog2(ROWS);
  localparam int BW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int TW = $clog2(max3(DIV, DWELL, BLANK) + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(COLS - 1);
  state_t st, nxt;
  logic [RW-1:0] row;
  logic [BW-1:0] bitc;
  logic [COLS-1:0] sreg;
  logic [TW-1:0] val;
  logic done;
  always_comb begin
    nxt = st;
    case (st)
      ST_IDLE:     nxt = en ? ST_BLANK : ST_IDLE;
      ST_BLANK:    nxt = done ? ST_FETCH : st;
      ST_FETCH:    nxt = done ? ST_SHIFT_LO : st;
      ST_SHIFT_LO: nxt = done ? ST_SHIFT_HI : st;
      ST_SHIFT_HI: nxt = done ? (bitc == LAST_BIT ? ST_LATCH : ST_SHIFT_LO) : st;
      ST_LATCH:    nxt = done ? ST_DISPLAY : st;
      ST_DISPLAY:  nxt = done ? (en ? ST_BLANK : ST_IDLE) : st;
      default:     nxt = ST_IDLE;
    endcase
  end
  assign val = nxt == ST_BLANK   ? TW'(BLANK - 1) :
               nxt == ST_FETCH   ? TW'(1) :
               nxt == ST_DISPLAY ? TW'(DWELL - 1) :
               nxt == ST_IDLE    ? '0 : TW'(DIV - 1);
  phase_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (nxt != st),
    .val  (val),
    .done (done)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st         <= ST_IDLE;
      row        <= '0;
      bitc       <= '0;
      sreg       <= '0;
      row_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      st         <= nxt;
      frame_done <= st == ST_DISPLAY && done && row == LAST_ROW;
      if (st == ST_FETCH && done) sreg <= rd_data;
      if (st == ST_SHIFT_HI && done) begin
        sreg <= sreg << 1;
        bitc <= bitc == LAST_BIT ? '0 : bitc + 1'b1;
      end
      if (nxt == ST_LATCH && st != ST_LATCH) row_sel <= ROWS'(1) << row;
      else if (nxt == ST_IDLE) row_sel <= '0;
      if (st == ST_DISPLAY && done) row <= row == LAST_ROW ? '0 : row + 1'b1;
    end
  assign rd_row = row;
  assign ser    = sreg[COLS-1];
  assign srclk  = st == ST_SHIFT_HI;
  assign rclk   = st == ST_LATCH;
  assign oe_n   = st != ST_DISPLAY;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: scoreboard bench for led_matrix_scanner with ROWS=8 COLS=8 DIV=2 DWELL=10 BLANK=3
module tb_led_matrix_scanner;
  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] data;
  } exp_t;
  logic clk = 0, rst = 1, en = 1;
  logic [2:0] rd_row;
  logic [7:0] rd_data = '0;
  logic ser, srclk, rclk, oe_n, frame_done;
  logic [7:0] row_sel;
  logic [7:0] fb [8];
  exp_t exp_q[$];
  int checks = 0, failures = 0;
  led_matrix_scanner #(.ROWS(8), .COLS(8), .DIV(2), .DWELL(10), .BLANK(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .ser        (ser),
    .srclk      (srclk),
    .rclk       (rclk),
    .oe_n       (oe_n),
    .row_sel    (row_sel),
    .frame_done (frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= fb[rd_row];
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout waiting for %s", name);
  endtask
  task automatic push_row(input int r);
    exp_q.push_back({8'(1 << r), fb[r]});
  endtask
  logic [7:0] collected, last_sel;
  logic prev_srclk, prev_rclk, prev_oe, have_prev;
  int cyc = 0, prev_cyc, dcnt;
  always @(negedge clk) begin
    if (rst) begin
      collected = '0; dcnt = 0; have_prev = 0;
      prev_srclk = 0; prev_rclk = 0; prev_oe = 1; last_sel = '0;
    end else begin
      if (srclk && !prev_srclk) collected = {collected[6:0], ser};
      if (rclk && !prev_rclk) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_latch: row_sel %0h with empty queue", row_sel);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("latch_row_sel", row_sel, e.sel);
          check("latch_data", collected, e.data);
        end
        if (have_prev) check("rclk_period", cyc - prev_cyc, 49);
        have_prev = 1;
        prev_cyc = cyc;
        last_sel = row_sel;
      end
      if (!oe_n) dcnt++;
      if (oe_n && !prev_oe) begin
        check("dwell", dcnt, 10);
        check("frame_done", frame_done, last_sel == 8'h80);
        dcnt = 0;
      end else if (frame_done) begin
        checks++;
        failures++;
        $display("FAIL frame_done_stray: got 1 expected 0 at cycle %0d", cyc);
      end
      if (row_sel == '0) have_prev = 0;
      prev_srclk = srclk;
      prev_rclk = rclk;
      prev_oe = oe_n;
    end
    cyc++;
  end
  initial begin
    int i;
    fb = '{8'hA5, 8'h3C, 8'h81, 8'h7E, 8'h01, 8'h80, 8'hFF, 8'h00};
    #1;
    check("rst_oe_n", oe_n, 1);
    check("rst_row_sel", row_sel, 0);
    check("rst_srclk", srclk, 0);
    check("rst_rclk", rclk, 0);
    repeat (4) @(negedge clk);
    check("rst_hold_oe_n", oe_n, 1);
    check("rst_hold_row_sel", row_sel, 0);
    check("rst_hold_ser", ser, 0);
    check("rst_hold_rd_row", rd_row, 0);
    check("rst_hold_frame_done", frame_done, 0);
    for (int r = 0; r < 8; r++) push_row(r);
    for (int r = 0; r < 3; r++) push_row(r);
    #2 rst = 0;
    for (i = 0; i < 2000 && !frame_done; i++) @(negedge clk);
    if (!frame_done) timeout("frame_done");
    check("wrap_rd_row", rd_row, 0);
    for (i = 0; i < 500 && !(rd_row == 2 && srclk); i++) @(negedge clk);
    if (!(rd_row == 2 && srclk)) timeout("row2_shift");
    en = 0;
    for (i = 0; i < 200 && oe_n; i++) @(negedge clk);
    for (i = 0; i < 200 && !oe_n; i++) @(negedge clk);
    if (!oe_n) timeout("row2_display_end");
    repeat (2) @(negedge clk);
    check("idle_oe_n", oe_n, 1);
    check("idle_row_sel", row_sel, 0);
    check("idle_rd_row", rd_row, 3);
    repeat (20) @(negedge clk);
    check("idle_hold_oe_n", oe_n, 1);
    check("idle_hold_srclk", srclk, 0);
    check("idle_hold_rclk", rclk, 0);
    for (int r = 3; r < 6; r++) push_row(r);
    en = 1;
    for (i = 0; i < 500 && !(row_sel == 8'h20 && !oe_n); i++) @(negedge clk);
    if (!(row_sel == 8'h20 && !oe_n)) timeout("row5_display");
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    check("async_rst_oe_n", oe_n, 1);
    check("async_rst_row_sel", row_sel, 0);
    check("async_rst_rd_row", rd_row, 0);
    repeat (3) @(negedge clk);
    push_row(0);
    push_row(1);
    rst = 0;
    check("post_rst_rd_row", rd_row, 0);
    for (i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) timeout("queue_drain");
    en = 0;
    for (i = 0; i < 200 && oe_n; i++) @(negedge clk);
    for (i = 0; i < 200 && !oe_n; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_row_sel", row_sel, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
